// File: rtl/clk_gate_ctrl.sv
// ============================================================================
//  Module   : clk_gate_ctrl
//  Purpose  : N-channel glitch-free clock-gate controller with software enable
//             and optional auto-sleep after IDLE_CYCLES idle busy samples.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module clk_gate_ctrl #(
    parameter int N_CH        = 4,
    parameter int IDLE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw_en,
    input  logic [N_CH-1:0] auto_en,
    input  logic [N_CH-1:0] busy,
    input  logic            test_en,
    output logic [N_CH-1:0] gated_clk,
    output logic [N_CH-1:0] clk_on,
    output logic [N_CH-1:0] wake_pulse
);

    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_IDLE  = 2'd2,
        ST_SLEEP = 2'd3
    } state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             en_q;
        logic             wake_q;
        logic             lat;

        // en_q is loaded with (next state is ON or IDLE) in every branch.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= ST_OFF;
                cnt    <= CNT_ZERO;
                en_q   <= 1'b0;
                wake_q <= 1'b0;
            end else begin
                wake_q <= 1'b0;
                if (!sw_en[i]) begin
                    state <= ST_OFF;
                    cnt   <= CNT_ZERO;
                    en_q  <= 1'b0;
                end else if (state == ST_OFF || !auto_en[i]) begin
                    state <= ST_ON;
                    cnt   <= CNT_ZERO;
                    en_q  <= 1'b1;
                end else begin
                    case (state)
                        ST_ON: begin
                            if (busy[i]) begin
                                state <= ST_ON;
                                cnt   <= CNT_ZERO;
                                en_q  <= 1'b1;
                            end else if (IDLE_CYCLES == 1) begin
                                state <= ST_SLEEP;
                                cnt   <= CNT_ZERO;
                                en_q  <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                                cnt   <= CNT_ONE;
                                en_q  <= 1'b1;
                            end
                        end
                        ST_IDLE: begin
                            if (busy[i]) begin
                                state <= ST_ON;
                                cnt   <= CNT_ZERO;
                                en_q  <= 1'b1;
                            end else if (cnt == CNT_LAST) begin
                                state <= ST_SLEEP;
                                cnt   <= CNT_ZERO;
                                en_q  <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                                cnt   <= cnt + CNT_ONE;
                                en_q  <= 1'b1;
                            end
                        end
                        ST_SLEEP: begin
                            cnt <= CNT_ZERO;
                            if (busy[i]) begin
                                state  <= ST_ON;
                                en_q   <= 1'b1;
                                wake_q <= 1'b1;
                            end else begin
                                state  <= ST_SLEEP;
                                en_q   <= 1'b0;
                            end
                        end
                        default: begin
                            state <= ST_OFF;
                            cnt   <= CNT_ZERO;
                            en_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        // Transparent only while clk is low, so a high phase is never cut short.
        always_latch begin
            if (!rst_n) begin
                lat <= 1'b0;
            end else if (!clk) begin
                lat <= en_q;
            end
        end

        assign gated_clk[i]  = clk & (lat | test_en);
        assign clk_on[i]     = en_q;
        assign wake_pulse[i] = wake_q;
    end

endmodule

`default_nettype wire
